// File: rtl/ram_port.sv
// Single-port 32-bit data memory behind a valid/ready request channel and a held
// response channel, with configurable response latency and access-fault flagging.
module ram_port #(
    parameter int ADDR_WIDTH = 20,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t r_state;
    state_t w_next_state;
    logic [3:0]  r_count;
    logic [3:0]  w_next_count;
    logic [31:0] r_rdata;
    logic        r_err;

    // Array has no reset and no preload, so unwritten words read as X.
    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

    logic                  w_accept;
    logic                  w_fault;
    logic                  w_oob;
    logic [1:0]            w_lane;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [31:0]           w_resp_data;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_lane   = req_addr[1:0];
    assign w_idx    = req_addr[ADDR_WIDTH+1:2];
    assign w_oob    = |(req_addr[31:2] >> ADDR_WIDTH);
    assign w_fault  = (req_func[1:0] == 2'b11)
                   || ((req_func[1:0] == 2'b01) && req_addr[0])
                   || ((req_func[1:0] == 2'b10) && (w_lane != 2'b00))
                   || w_oob;

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = req_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'h0;
        case (req_func[1:0])
            2'b00:   w_load = req_func[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = req_func[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            2'b10:   w_load = w_word;
            default: w_load = 32'h0;
        endcase
    end

    assign w_resp_data = (req_rw || w_fault) ? 32'h0 : w_load;

    // Stores commit at the acceptance edge so a later load always sees them.
    always_ff @(posedge clk) begin
        if (w_accept && !rst && req_rw && !w_fault) begin
            case (req_func[1:0])
                2'b00:   r_mem[w_idx][{w_lane, 3'b000} +: 8]   <= req_wdata[7:0];
                2'b01:   r_mem[w_idx][{w_lane[1], 4'b0000} +: 16] <= req_wdata[15:0];
                2'b10:   r_mem[w_idx] <= req_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = BUSY;
                        w_next_count = LAT_M1;
                    end
                end
            end
            BUSY: begin
                w_next_count = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_accept) begin
                r_rdata <= w_resp_data;
                r_err   <= w_fault;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_ram_port.sv
// Randomised bench for ram_port: two instances (latency 1 and 4, small address
// spaces) checked against a byte-array reference model plus directed scenarios.
module tb_ram_port;

    localparam int AW0     = 10;
    localparam int LAT0    = 1;
    localparam int AW1     = 8;
    localparam int LAT1    = 4;
    localparam int MAXWAIT = 64;
    localparam int NOPS    = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        reqValid  [2] = '{1'b0, 1'b0};
    logic        reqRw     [2] = '{1'b0, 1'b0};
    logic [2:0]  reqFunc   [2] = '{3'd0, 3'd0};
    logic [31:0] reqAddr   [2] = '{32'd0, 32'd0};
    logic [31:0] reqWdata  [2] = '{32'd0, 32'd0};
    logic        respReady [2] = '{1'b0, 1'b0};
    logic        reqReady  [2];
    logic        respValid [2];
    logic [31:0] respRdata [2];
    logic        respErr   [2];

    int checks = 0;
    int fails  = 0;

    logic [7:0] modelMem [2][4096];

    always #5 clk = ~clk;

    ram_port #(.ADDR_WIDTH(AW0), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_rw(reqRw[0]),
        .req_func(reqFunc[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    ram_port #(.ADDR_WIDTH(AW1), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_rw(reqRw[1]),
        .req_func(reqFunc[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: byte-addressed memory; returns {err, rdata} and applies stores.
    function automatic logic [32:0] modelAccess(input int d, input logic rw, input logic [2:0] func,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int aw;
        longint val;
        aw = (d == 0) ? AW0 : AW1;
        n  = 1 << func[1:0];
        if (func[1:0] == 2'b11 || (addr % 32'(n)) != 0 || (addr >> 2) >= 32'(1 << aw))
            return {1'b1, 32'h0};
        if (rw) begin
            for (int i = 0; i < n; i++) modelMem[d][addr + 32'(i)] = wdata[8*i +: 8];
            return 33'h0;
        end
        val = 0;
        for (int i = 0; i < n; i++) val = val | (longint'(modelMem[d][addr + 32'(i)]) << (8 * i));
        if (n < 4 && !func[2] && val[8*n-1]) val = val - (longint'(1) << (8 * n));
        return {1'b0, val[31:0]};
    endfunction

    task automatic sendReq(input int d, input logic rw, input logic [2:0] func, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [32:0] expected, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        expected = 33'h0;
        @(negedge clk);
        reqValid[d] = 1'b1;
        reqRw[d]    = rw;
        reqFunc[d]  = func;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        while (!reqReady[d] && waited < MAXWAIT) begin
            @(negedge clk);
            waited++;
        end
        if (!reqReady[d]) begin
            checkOutput("acceptTimeout", {31'b0, reqReady[d]}, 32'd1);
            reqValid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        expected = modelAccess(d, rw, func, addr, wdata);
        ok = 1'b1;
        #1;
        reqValid[d] = 1'b0;
        reqRw[d]    = 1'($urandom);
        reqFunc[d]  = 3'($urandom);
        reqAddr[d]  = $urandom;
        reqWdata[d] = $urandom;
    endtask

    // holdCycles < 0 randomises resp_ready; otherwise it stays low that many cycles.
    task automatic waitResp(input int d, input logic [32:0] expected, input int holdCycles,
                            output logic [31:0] rdata, output logic err);
        int cyc;
        int held;
        int lat;
        logic [31:0] r0;
        logic e0;
        lat  = (d == 0) ? LAT0 : LAT1;
        cyc  = 1;
        held = 0;
        rdata = 32'h0;
        err = 1'b0;
        @(negedge clk);
        while (!respValid[d] && cyc < MAXWAIT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("respValid", {31'b0, respValid[d]}, 32'd1);
        checkOutput("latency", cyc, lat);
        if (!respValid[d]) return;
        r0 = respRdata[d];
        e0 = respErr[d];
        forever begin
            if (holdCycles < 0) respReady[d] = ($urandom_range(3) != 0) || (held >= MAXWAIT);
            else                respReady[d] = (held >= holdCycles);
            @(posedge clk);
            if (respReady[d]) break;
            @(negedge clk);
            held++;
            checkOutput("holdRdata", respRdata[d], r0);
            checkOutput("holdCtrl", {29'b0, respValid[d], reqReady[d], respErr[d]}, {29'b0, 1'b1, 1'b0, e0});
        end
        #1 respReady[d] = 1'b0;
        rdata = r0;
        err   = e0;
        checkOutput("rdata", r0, expected[31:0]);
        checkOutput("err", {31'b0, e0}, {31'b0, expected[32]});
        @(negedge clk);
        checkOutput("released", {30'b0, respValid[d], reqReady[d]}, 32'd1);
    endtask

    task automatic applyStimulus(input int d, input logic rw, input logic [2:0] func, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int holdCycles,
                                 output logic [31:0] rdata, output logic err);
        logic [32:0] expected;
        bit ok;
        rdata = 32'h0;
        err = 1'b0;
        sendReq(d, rw, func, addr, wdata, expected, ok);
        if (ok) waitResp(d, expected, holdCycles, rdata, err);
    endtask

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [32:0] e1;
        logic [32:0] e2;
        bit ok;
        logic [31:0] heldData;
        int aw;
        int n;
        logic [2:0] func;
        logic [31:0] addr;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            checkOutput("resetState", {respRdata[d][30:0], respErr[d], respValid[d], reqReady[d]} ^ {respRdata[d][31], 31'b0} ,
                        32'd1);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            checkOutput("postResetRdata", respRdata[d], 32'h0);

        // Fill every word so random loads never read uninitialised data.
        for (int d = 0; d < 2; d++) begin
            aw = (d == 0) ? AW0 : AW1;
            for (int w = 0; w < (1 << aw); w++)
                applyStimulus(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, rd, er);
        end

        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, rd, er);
            applyStimulus(d, 1'b0, 3'b010, 32'h100, 32'h0, 0, rd, er);
            checkOutput("loadDeadbeef", rd, 32'hDEADBEEF);
            checkOutput("loadDeadbeefErr", {31'b0, er}, 32'd0);
        end

        applyStimulus(1, 1'b1, 3'b010, 32'h100, 32'h11223344, 0, rd, er);
        applyStimulus(1, 1'b1, 3'b000, 32'h103, 32'h00000080, 0, rd, er);
        applyStimulus(1, 1'b0, 3'b010, 32'h100, 32'h0, 0, rd, er);
        checkOutput("mergedWord", rd, 32'h80223344);
        applyStimulus(1, 1'b0, 3'b000, 32'h103, 32'h0, 0, rd, er);
        checkOutput("signedByte", rd, 32'hFFFFFF80);
        applyStimulus(1, 1'b0, 3'b100, 32'h103, 32'h0, 0, rd, er);
        checkOutput("unsignedByte", rd, 32'h00000080);
        applyStimulus(1, 1'b0, 3'b001, 32'h102, 32'h0, 0, rd, er);
        checkOutput("signedHalf", rd, 32'hFFFF8022);

        applyStimulus(0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 0, rd, er);
        applyStimulus(0, 1'b1, 3'b010, 32'h106, 32'h12345678, 0, rd, er);
        checkOutput("faultMisWord", {er, rd[30:0]} ^ {1'b0, rd[31], 30'b0}, 32'h80000000);
        applyStimulus(0, 1'b0, 3'b001, 32'h101, 32'h0, 0, rd, er);
        checkOutput("faultMisHalf", {31'b0, er}, 32'd1);
        applyStimulus(0, 1'b1, 3'b011, 32'h104, 32'h87654321, 0, rd, er);
        checkOutput("faultFunc", {31'b0, er}, 32'd1);
        applyStimulus(0, 1'b0, 3'b010, 32'h1000, 32'h0, 0, rd, er);
        checkOutput("faultRange", {31'b0, er}, 32'd1);
        checkOutput("faultRangeData", rd, 32'h0);
        applyStimulus(0, 1'b0, 3'b010, 32'h104, 32'h0, 0, rd, er);
        checkOutput("faultKeepsWord", rd, 32'hCAFEF00D);

        // Back-pressure with a queued request waiting behind the held response.
        sendReq(0, 1'b0, 3'b010, 32'h104, 32'h0, e1, ok);
        @(negedge clk);
        checkOutput("bpValid", {31'b0, respValid[0]}, 32'd1);
        heldData = respRdata[0];
        reqValid[0] = 1'b1;
        reqRw[0]    = 1'b0;
        reqFunc[0]  = 3'b010;
        reqAddr[0]  = 32'h100;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bpHoldData", respRdata[0], heldData);
            checkOutput("bpHoldCtrl", {30'b0, respValid[0], reqReady[0]}, 32'd2);
        end
        checkOutput("bpData", heldData, e1[31:0]);
        respReady[0] = 1'b1;
        @(posedge clk);
        #1 respReady[0] = 1'b0;
        checkOutput("bpRelease", {30'b0, respValid[0], reqReady[0]}, 32'd1);
        @(posedge clk);
        e2 = modelAccess(0, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        checkOutput("bpAccepted", {31'b0, reqReady[0]}, 32'd0);
        reqValid[0] = 1'b0;
        waitResp(0, e2, 0, rd, er);
        checkOutput("bpSecond", rd, 32'hDEADBEEF);

        // Reset while a latency-4 store is still counting down.
        sendReq(1, 1'b1, 3'b010, 32'h10, 32'h0A0B0C0D, e1, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midResetCtrl", {30'b0, respValid[1], reqReady[1]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("midResetIdle", {30'b0, respValid[1], reqReady[1]}, 32'd1);
        end
        applyStimulus(1, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
        checkOutput("storeSurvivesReset", rd, 32'h0A0B0C0D);

        for (int d = 0; d < 2; d++) begin
            aw = (d == 0) ? AW0 : AW1;
            for (int k = 0; k < NOPS; k++) begin
                func[1:0] = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
                func[2]   = 1'($urandom);
                n = 1 << func[1:0];
                addr = 32'($urandom_range(4 * (1 << aw) - 1));
                if (func[1:0] != 2'b11 && $urandom_range(7) != 0) addr = addr & ~32'(n - 1);
                if ($urandom_range(31) == 0) addr = $urandom;
                applyStimulus(d, 1'($urandom), func, addr, $urandom, -1, rd, er);
            end
        end

        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end

endmodule
